// File: rtl/rtmc_pkg.sv
// rtl/rtmc_pkg.sv - shared types and constants for the RTMC SPI register path
package rtmc_pkg;

  localparam int ADDR_W              = 8;
  localparam int DATA_W              = 16;
  localparam int BUS_TIMEOUT_DEFAULT = 255;

  typedef enum logic [7:0] {
    O_NOP = 8'h00,
    O_RD  = 8'h01,
    O_WR  = 8'h02
  } op_t;

  typedef enum logic [7:0] {
    R_BUSY     = 8'h00,
    R_ACK      = 8'h01,
    R_ACK_DATA = 8'h02,
    R_ERROR    = 8'hFF
  } result_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_WDH,
    S_WDL,
    S_BUS,
    S_RESP,
    S_END,
    S_ERR,
    S_DRAIN
  } cmd_state_t;

endpackage

// File: rtl/rtmc_bus_timer.sv
// rtl/rtmc_bus_timer.sv - 8-bit wait counter that flags a bus request left unanswered for LIMIT cycles
module rtmc_bus_timer
  import rtmc_pkg::*;
#(
  parameter int LIMIT = BUS_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count,
  input  logic clear,
  output logic expire
);

  logic [7:0] cnt;

  // expire is asserted during the LIMIT-th counted cycle, so the request is held exactly LIMIT cycles
  assign expire = count && (cnt == 8'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clear) begin
      cnt <= 8'd0;
    end else if (count && !expire) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/rtmc_spi_cmd.sv
// rtl/rtmc_spi_cmd.sv - SPI byte stream to register bus sequencer, one read or write per CS frame
// Optional bus-ack timeout enabled by defining RTMC_CMD_TIMEOUT_EN.
module rtmc_spi_cmd
  import rtmc_pkg::*;
#(
  parameter int BUS_TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_ack,
  output logic              busy
);

  cmd_state_t        state, state_d;
  logic              is_rd, is_rd_d;
  logic [1:0]        resp_cnt, resp_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        tx_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              wr_d, rd_d;
  logic              byte_in, ack, timeout;

  // a byte coinciding with frame low belongs to no frame and is dropped
  assign byte_in = rx_valid && frame;
  assign ack     = reg_ack && (reg_wr || reg_rd);
  assign busy    = (state != S_IDLE);

`ifdef RTMC_CMD_TIMEOUT_EN
  logic in_wait;
  assign in_wait = (state == S_BUS) || (state == S_DRAIN);

  rtmc_bus_timer #(
    .LIMIT(BUS_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .count (in_wait),
    .clear (!in_wait),
    .expire(timeout)
  );
`else
  logic [7:0] unused_bus_timeout;
  assign unused_bus_timeout = 8'(BUS_TIMEOUT);
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      is_rd     <= 1'b0;
      resp_cnt  <= 2'd0;
      rdata_q   <= '0;
      tx_byte   <= R_BUSY;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
    end else begin
      state     <= state_d;
      is_rd     <= is_rd_d;
      resp_cnt  <= resp_cnt_d;
      rdata_q   <= rdata_d;
      tx_byte   <= tx_d;
      reg_addr  <= addr_d;
      reg_wdata <= wdata_d;
      reg_wr    <= wr_d;
      reg_rd    <= rd_d;
    end
  end

  always_comb begin
    state_d    = state;
    is_rd_d    = is_rd;
    resp_cnt_d = resp_cnt;
    rdata_d    = rdata_q;
    tx_d       = tx_byte;
    addr_d     = reg_addr;
    wdata_d    = reg_wdata;
    wr_d       = reg_wr;
    rd_d       = reg_rd;

    case (state)
      S_IDLE: begin
        if (byte_in) begin
          case (rx_byte)
            O_WR: begin
              is_rd_d = 1'b0;
              state_d = S_ADDR;
            end
            O_RD: begin
              is_rd_d = 1'b1;
              state_d = S_ADDR;
            end
            O_NOP: state_d = S_IDLE;
            default: begin
              state_d = S_ERR;
              tx_d    = R_ERROR;
            end
          endcase
        end
      end

      S_ADDR: begin
        if (!frame) begin
          state_d = S_IDLE;
          tx_d    = R_BUSY;
        end else if (byte_in) begin
          addr_d = rx_byte[ADDR_W-1:0];
          if (is_rd) begin
            state_d = S_BUS;
            rd_d    = 1'b1;
          end else begin
            state_d = S_WDH;
          end
        end
      end

      S_WDH: begin
        if (!frame) begin
          state_d = S_IDLE;
          tx_d    = R_BUSY;
        end else if (byte_in) begin
          wdata_d[15:8] = rx_byte;
          state_d       = S_WDL;
        end
      end

      S_WDL: begin
        if (!frame) begin
          state_d = S_IDLE;
          tx_d    = R_BUSY;
        end else if (byte_in) begin
          wdata_d[7:0] = rx_byte;
          state_d      = S_BUS;
          wr_d         = 1'b1;
        end
      end

      // poll bytes are absorbed here; the ack wins over a same-cycle byte
      S_BUS: begin
        if (ack) begin
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          rdata_d = reg_rdata;
          if (frame) begin
            state_d    = S_RESP;
            resp_cnt_d = 2'd0;
            tx_d       = is_rd ? R_ACK_DATA : R_ACK;
          end else begin
            state_d = S_IDLE;
          end
        end else if (timeout) begin
          wr_d = 1'b0;
          rd_d = 1'b0;
          if (frame) begin
            state_d = S_ERR;
            tx_d    = R_ERROR;
          end else begin
            state_d = S_IDLE;
          end
        end else if (!frame) begin
          state_d = S_DRAIN;
        end
      end

      S_RESP: begin
        if (!frame) begin
          state_d = S_IDLE;
          tx_d    = R_BUSY;
        end else if (byte_in) begin
          if (!is_rd) begin
            tx_d    = R_BUSY;
            state_d = S_END;
          end else begin
            case (resp_cnt)
              2'd0: begin
                tx_d       = rdata_q[15:8];
                resp_cnt_d = 2'd1;
              end
              2'd1: begin
                tx_d       = rdata_q[7:0];
                resp_cnt_d = 2'd2;
              end
              default: begin
                tx_d    = R_BUSY;
                state_d = S_END;
              end
            endcase
          end
        end
      end

      S_END, S_ERR: begin
        if (!frame) begin
          state_d = S_IDLE;
          tx_d    = R_BUSY;
        end
      end

      // a frame that opens while the old request drains is unusable and errors out
      S_DRAIN: begin
        if (ack || timeout) begin
          wr_d = 1'b0;
          rd_d = 1'b0;
          if (frame) begin
            state_d = S_ERR;
            tx_d    = R_ERROR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = R_BUSY;
      end
    endcase
  end

endmodule

// File: tb/tb_rtmc_spi_cmd.sv
// tb/tb_rtmc_spi_cmd.sv - directed frames against a slot-level response model and bus expectations
module tb_rtmc_spi_cmd;
  import rtmc_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n, frame, rx_valid, reg_wr, reg_rd, reg_ack, busy;
  logic [7:0]        rx_byte, tx_byte;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata, reg_rdata;

  always #5 clk = ~clk;

  rtmc_spi_cmd #(.BUS_TIMEOUT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame    (frame),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .tx_byte  (tx_byte),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr   (reg_wr),
    .reg_rd   (reg_rd),
    .reg_rdata(reg_rdata),
    .reg_ack  (reg_ack),
    .busy     (busy)
  );

  int vectors = 0, miscompares = 0;
  logic [7:0]  exp_tx[$];
  logic [7:0]  cap[$];
  logic        exp_wr = 1'b0, exp_rd = 1'b0, exp_resp_chk = 1'b0;
  logic [7:0]  exp_addr = 8'h00, exp_resp = 8'h00;
  logic [15:0] exp_wd = 16'h0000, rdata_val = 16'h0000;
  bit          ack_en = 1'b1;
  int          ack_delay = 1;
  int          cyc = 0, last_rx_cyc = 0, n_req = 0;
  logic        prev_req = 1'b0, ack_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slot model: what the host must read in each byte slot of a frame whose bus ack lands between slots.
  function automatic void push_exp(input logic [7:0] op, input int n, input logic [15:0] rd);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      if (i == 0) e = 8'h00;
      else if (op == 8'h02) e = (i == 4) ? 8'h01 : 8'h00;
      else if (op == 8'h01) e = (i == 2) ? 8'h02 : (i == 3) ? rd[15:8] : (i == 4) ? rd[7:0] : 8'h00;
      else if (op == 8'h00) e = 8'h00;
      else e = 8'hFF;
      exp_tx.push_back(e);
    end
  endfunction

  task automatic set_bus(input logic wr, input logic rd, input logic [7:0] a, input logic [15:0] wd,
                         input logic rchk, input logic [7:0] r);
    exp_wr = wr; exp_rd = rd; exp_addr = a; exp_wd = wd; exp_resp_chk = rchk; exp_resp = r;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic start_frame();
    @(negedge clk);
    frame = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    frame = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("slots_left", exp_tx.size(), 0);
    chk("busy_idle", busy, 1'b0);
    exp_tx.delete();
  endtask

  task automatic send_frame(input logic [7:0] b[$]);
    start_frame();
    foreach (b[i]) send_byte(b[i], 8);
    end_frame();
  endtask

  // Bus responder: acks any request ack_delay cycles after it is first seen.
  initial begin
    reg_ack   = 1'b0;
    reg_rdata = '0;
    forever begin
      @(negedge clk);
      if ((reg_wr || reg_rd) && ack_en) begin
        repeat (ack_delay) @(negedge clk);
        reg_rdata = rdata_val;
        reg_ack   = 1'b1;
        @(negedge clk);
        reg_ack = 1'b0;
      end
    end
  end

  // Compare process, sampled 1 time unit after each falling edge.
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      prev_req = 1'b0;
      ack_pend = 1'b0;
    end else begin
      if (rx_valid && frame) begin
        if (exp_tx.size() == 0) chk("tx_unexpected_slot", tx_byte, 8'hxx);
        else chk("tx_slot", tx_byte, exp_tx.pop_front());
        cap.push_back(tx_byte);
        last_rx_cyc = cyc;
      end
      if (reg_wr || reg_rd) begin
        chk("bus_req", {reg_wr, reg_rd, reg_addr, (reg_wr ? reg_wdata : 16'h0)},
            {exp_wr, exp_rd, exp_addr, (exp_wr ? exp_wd : 16'h0)});
        if (!prev_req) begin
          n_req++;
          chk("req_latency", cyc - last_rx_cyc, 1);
        end
      end
      if (ack_pend) chk("resp_latency", tx_byte, exp_resp);
      ack_pend = reg_ack && (reg_wr || reg_rd) && exp_resp_chk && frame;
      prev_req = reg_wr || reg_rd;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd_lit[5];
    logic [7:0] bad_lit[3];
    int n0, n;
    rd_lit  = '{8'h00, 8'h00, 8'h02, 8'hBE, 8'hEF};
    bad_lit = '{8'h00, 8'hFF, 8'hFF};
    rst_n = 1'b0; frame = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", tx_byte, 8'h00);
    chk("rst_addr", reg_addr, 8'h00);
    chk("rst_wdata", reg_wdata, 16'h0000);
    chk("rst_wr", reg_wr, 1'b0);
    chk("rst_rd", reg_rd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write frame, ack after 3 cycles
    n0 = n_req; ack_delay = 3;
    set_bus(1, 0, 8'h02, 16'h1234, 1, 8'h01);
    push_exp(8'h02, 5, 16'h0);
    start_frame();
    send_byte(8'h02, 8);
    #1 chk("busy_after_op", busy, 1'b1);
    send_byte(8'h02, 8); send_byte(8'h12, 8); send_byte(8'h34, 8); send_byte(8'h00, 8);
    end_frame();
    chk("wr_req_count", n_req - n0, 1);

    // read frame, rdata 0xBEEF, ack after 1 cycle
    n0 = n_req; ack_delay = 1; rdata_val = 16'hBEEF; cap.delete();
    set_bus(0, 1, 8'h00, 16'h0, 1, 8'h02);
    push_exp(8'h01, 5, 16'hBEEF);
    send_frame('{8'h01, 8'h00, 8'h00, 8'h00, 8'h00});
    chk("rd_req_count", n_req - n0, 1);
    chk("rd_cap_len", cap.size(), 5);
    for (int i = 0; i < 5 && i < cap.size(); i++) chk("rd_literal", cap[i], rd_lit[i]);

    // unknown op 0x55 errors the frame with no bus activity
    n0 = n_req; cap.delete();
    set_bus(0, 0, 8'h00, 16'h0, 0, 8'h00);
    push_exp(8'h55, 3, 16'h0);
    send_frame('{8'h55, 8'h00, 8'h00});
    chk("bad_req_count", n_req - n0, 0);
    chk("bad_cap_len", cap.size(), 3);
    for (int i = 0; i < 3 && i < cap.size(); i++) chk("bad_literal", cap[i], bad_lit[i]);

    // following write proceeds normally
    n0 = n_req; ack_delay = 2;
    set_bus(1, 0, 8'h10, 16'hABCD, 1, 8'h01);
    push_exp(8'h02, 6, 16'h0);
    send_frame('{8'h02, 8'h10, 8'hAB, 8'hCD, 8'h00, 8'h00});
    chk("wr2_req_count", n_req - n0, 1);

    // frame drops while a read is outstanding, new frame opens during drain
    n0 = n_req; ack_delay = 10; rdata_val = 16'h1111;
    set_bus(0, 1, 8'h07, 16'h0, 0, 8'h00);
    exp_tx.push_back(8'h00); exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
    exp_tx.push_back(8'hFF); exp_tx.push_back(8'hFF);
    start_frame();
    send_byte(8'h01, 8);
    send_byte(8'h07, 1);
    @(negedge clk);
    frame = 1'b0;
    @(negedge clk);
    #1 chk("drain_hold", reg_rd, 1'b1);
    chk("drain_busy", busy, 1'b1);
    @(negedge clk);
    frame = 1'b1;
    send_byte(8'h00, 1);
    #1 chk("drain_hold2", reg_rd, 1'b1);
    n = 0;
    while (reg_rd && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_release", reg_rd, 1'b0);
    send_byte(8'h00, 8);
    send_byte(8'h00, 8);
    end_frame();
    chk("drain_req_count", n_req - n0, 1);

    // async reset while a write is pending; the late ack must be ignored
    n0 = n_req; ack_delay = 50;
    set_bus(1, 0, 8'h05, 16'h0000, 0, 8'h00);
    push_exp(8'h02, 4, 16'h0);
    start_frame();
    send_byte(8'h02, 8); send_byte(8'h05, 8); send_byte(8'h00, 8); send_byte(8'h00, 1);
    #1 chk("pre_reset_wr", reg_wr, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_wr", reg_wr, 1'b0);
    @(negedge clk);
    frame = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    chk("post_reset_wr", reg_wr, 1'b0);
    chk("post_reset_addr", reg_addr, 8'h00);
    chk("post_reset_tx", tx_byte, 8'h00);
    chk("reset_req_count", n_req - n0, 1);
    set_bus(0, 0, 8'h00, 16'h0, 0, 8'h00);
    push_exp(8'h00, 3, 16'h0);
    send_frame('{8'h00, 8'h00, 8'h00});

`ifdef RTMC_CMD_TIMEOUT_EN
    // ack never arrives: request held exactly 4 cycles, then error
    n0 = n_req; ack_en = 1'b0;
    set_bus(0, 1, 8'h09, 16'h0, 0, 8'h00);
    exp_tx.push_back(8'h00); exp_tx.push_back(8'h00); exp_tx.push_back(8'hFF);
    start_frame();
    send_byte(8'h01, 8);
    send_byte(8'h09, 0);
    n = 0;
    #1;
    while (reg_rd && n < 50) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("timeout_cycles", n, 4);
    send_byte(8'h00, 8);
    end_frame();
    chk("timeout_req_count", n_req - n0, 1);
    ack_en = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
